// File: rtl/ofs_fim_pcie_ss_ib2sb.sv
// In-band to side-band TLP header converter: strips the 256-bit SOP header into out_tuser_vendor and realigns payload down.
// Optional protocol checking enabled by defining OFS_FIM_PCIE_SS_IB2SB_ERR_CHK_EN.
module ofs_fim_pcie_ss_ib2sb #(
    parameter int DATA_WIDTH = 512,
    parameter int HDR_WIDTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_tkeep,
    input  logic                    in_tlast,
    input  logic                    in_tuser_vendor,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tkeep,
    output logic                    out_tlast,
    output logic [HDR_WIDTH:0]      out_tuser_vendor,
    output logic                    err
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int KH = HDR_WIDTH / 8;
    localparam int U  = DATA_WIDTH - HDR_WIDTH;
    localparam int KU = U / 8;

    typedef enum logic [1:0] {ST_SOP = 2'd0, ST_BODY = 2'd1, ST_FLUSH = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [U-1:0]          hold_data_q, hold_data_d;
    logic [KU-1:0]         hold_keep_q, hold_keep_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                  dm_q, dm_d, first_q, first_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KW-1:0]         out_keep_q, out_keep_d;
    logic [HDR_WIDTH:0]    out_user_q, out_user_d;

    logic                  ld_s, acc_s, upper_keep_s;
    logic                  emit_s, emit_last_s, emit_dm_s;
    logic [DATA_WIDTH-1:0] emit_data_s;
    logic [KW-1:0]         emit_keep_s;
    logic [HDR_WIDTH-1:0]  emit_hdr_s;

    assign ld_s         = !out_valid_q || out_tready;
    assign in_tready    = rst_n && ld_s && (state_q != ST_FLUSH);
    assign acc_s        = in_tvalid && in_tready;
    assign upper_keep_s = |in_tkeep[KW-1:KH];

    // State register and per-packet holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SOP;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hdr_q       <= '0;
            dm_q        <= 1'b0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hdr_q       <= hdr_d;
            dm_q        <= dm_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
        end
    end

    // Next-state logic; a last beat with upper bytes needs an extra flush beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SOP:   state_d = (acc_s && !in_tlast) ? ST_BODY : ST_SOP;
            ST_BODY: begin
                if (acc_s && in_tlast) begin
                    state_d = upper_keep_s ? ST_FLUSH : ST_SOP;
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_FLUSH: state_d = ld_s ? ST_SOP : ST_FLUSH;
            default:  state_d = ST_SOP;
        endcase
    end

    // Beat emission and holding-register updates.
    always_comb begin
        emit_s      = 1'b0;
        emit_last_s = 1'b0;
        emit_dm_s   = dm_q;
        emit_data_s = '0;
        emit_keep_s = '0;
        emit_hdr_s  = '0;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hdr_d       = hdr_q;
        dm_d        = dm_q;
        first_d     = first_q;
        case (state_q)
            ST_SOP: begin
                if (acc_s) begin
                    hdr_d       = in_tdata[HDR_WIDTH-1:0];
                    dm_d        = in_tuser_vendor;
                    hold_data_d = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                    hold_keep_d = in_tkeep[KW-1:KH];
                    if (in_tlast) begin
                        emit_s      = 1'b1;
                        emit_last_s = 1'b1;
                        emit_dm_s   = in_tuser_vendor;
                        emit_data_s = {{HDR_WIDTH{1'b0}}, in_tdata[DATA_WIDTH-1:HDR_WIDTH]};
                        emit_keep_s = {{KH{1'b0}}, in_tkeep[KW-1:KH]};
                        emit_hdr_s  = in_tdata[HDR_WIDTH-1:0];
                        first_d     = 1'b0;
                    end else begin
                        first_d     = 1'b1;
                    end
                end else begin
                    first_d = first_q;
                end
            end
            ST_BODY: begin
                if (acc_s) begin
                    emit_s      = 1'b1;
                    emit_last_s = in_tlast && !upper_keep_s;
                    emit_data_s = {in_tdata[HDR_WIDTH-1:0], hold_data_q};
                    emit_keep_s = {in_tkeep[KH-1:0], hold_keep_q};
                    emit_hdr_s  = first_q ? hdr_q : {HDR_WIDTH{1'b0}};
                    first_d     = 1'b0;
                    hold_data_d = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                    hold_keep_d = in_tkeep[KW-1:KH];
                end else begin
                    first_d = first_q;
                end
            end
            ST_FLUSH: begin
                if (ld_s) begin
                    emit_s      = 1'b1;
                    emit_last_s = 1'b1;
                    emit_data_s = {{HDR_WIDTH{1'b0}}, hold_data_q};
                    emit_keep_s = {{KH{1'b0}}, hold_keep_q};
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: emit_s = 1'b0;
        endcase
    end

    // Output register: loads only when empty or being drained, so a stalled beat holds.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        if (ld_s) begin
            out_valid_d = emit_s;
            if (emit_s) begin
                out_data_d = emit_data_s;
                out_keep_d = emit_keep_s;
                out_last_d = emit_last_s;
                out_user_d = {emit_hdr_s, emit_dm_s};
            end else begin
                out_last_d = out_last_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign out_tvalid       = out_valid_q;
    assign out_tdata        = out_data_q;
    assign out_tkeep        = out_keep_q;
    assign out_tlast        = out_last_q;
    assign out_tuser_vendor = out_user_q;

`ifdef OFS_FIM_PCIE_SS_IB2SB_ERR_CHK_EN
    logic err_q, err_d;

    // Contiguous-from-bit-0 keep has no set bit above a clear bit.
    function automatic logic keep_contig(input logic [KW-1:0] k);
        return ((k & (k + KW'(1))) == {KW{1'b0}});
    endfunction

    // Sticky error flag.
    always_comb begin
        err_d = err_q;
        if (acc_s && ((state_q == ST_SOP && in_tkeep[KH-1:0] != {KH{1'b1}}) || !keep_contig(in_tkeep))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
